pipe_phy_cmd_ctrl: RTL and testbench
====================================

// Module: pipe_phy_cmd_ctrl
// PURPOSE
// PHY-side responder for the PIPE command/status signals; drives PhyStatus/RxStatus back to the MAC.
// Handles reset completion, PowerDown and Rate change handshakes, and receiver detection.
// Used by the PHY model behind the PIPE interface; the pipe agent monitors these signals.
// PARAMETERS
// NUM_LANES      16       lane count; sets PhyStatus/RxStatus/TxDetectRxLoopback widths
// RESET_LAT      8        cycles PhyStatus stays high after Reset deasserts (>=2)
// RATE_LAT       16       Rate-change latency in PCLK cycles (>=2)
// PD_LAT         4        PowerDown-change latency in PCLK cycles (>=2)
// DETECT_LAT     12       receiver-detect latency in PCLK cycles (>=2)
// RX_PRESENT     '1       NUM_LANES-bit mask; bit=1 means a far-end receiver is present on that lane
// PORTS
// PCLK                in   1            PIPE clock; the only clock
// Reset               in   1            synchronous, active-high reset
// PowerDown           in   4            MAC request: 0=P0, 1=P0s, 2=P1, 3=P2; values >3 are illegal
// Rate                in   4            MAC request: 0..4 = Gen1..Gen5; values >4 are illegal
// TxDetectRxLoopback  in   NUM_LANES    per-lane receiver-detect request
// TxElecIdle          in   NUM_LANES    per-lane transmitter electrical-idle
// PhyStatus           out  NUM_LANES    completion pulse (all lanes driven identically)
// RxStatus            out  3*NUM_LANES  per-lane status; lane i occupies bits [3i+2:3i]
// busy                out  1            high in any state other than IDLE
// cur_rate            out  4            currently accepted Rate
// cur_powerdown       out  4            currently accepted PowerDown
// BEHAVIOUR
// - Reset=1 (sampled at a PCLK edge) forces the following, whatever the current state:
//   state=RST_WAIT, PhyStatus='1, RxStatus=0, busy=1, cur_rate=0, cur_powerdown=2 (P1), counter cleared.
// - RST_WAIT: counter runs only while Reset=0.
//   PhyStatus stays '1 for exactly RESET_LAT cycles after the first edge with Reset=0.
//   Then PhyStatus=0 and the block enters IDLE.
// - IDLE: compares the inputs every cycle; the first matching rule is taken:
//   (1) Rate legal and != cur_rate                                  -> RATE_CHG, LAT=RATE_LAT
//   (2) PowerDown legal and != cur_powerdown                        -> PD_CHG, LAT=PD_LAT
//   (3) cur_powerdown==2, |TxDetectRxLoopback, &TxElecIdle          -> DETECT, LAT=DETECT_LAT
//   - The triggering value is captured at the decision edge (cycle T).
//   - Inputs are ignored while busy. Any pending difference is re-evaluated on the first IDLE cycle.
// - Completion: PhyStatus='1 for exactly one cycle, at cycle T+LAT.
//   - In the same cycle, cur_rate or cur_powerdown updates to the captured value.
//   - RATE_CHG and PD_CHG then return to IDLE on the next cycle.
// - DETECT completion: in the PhyStatus cycle, RxStatus lane i = 3'b011 if captured detect[i] & RX_PRESENT[i], else 3'b000.
//   - The state then becomes DET_WAIT.
//   - DET_WAIT holds busy=1 until TxDetectRxLoopback==0, then returns to IDLE.
// - RxStatus is 0 in every cycle other than a DETECT completion cycle.
// - PhyStatus is 0 except in RST_WAIT and in completion cycles.
// - Illegal PowerDown/Rate values never trigger a transition and produce no PhyStatus.
//   cur_* values are unchanged.
// - A Rate and PowerDown change in the same cycle are serviced sequentially:
//   - Rate first.
//   - The PowerDown change is decided on the first IDLE cycle after the Rate completion.
// - The latency counter is wide enough for max(RESET_LAT, RATE_LAT, PD_LAT, DETECT_LAT); no wrap-around.
// TESTING
// 1. Reset high for 3 cycles, then low -> PhyStatus='1 for 8 cycles after deassert, then 0; busy=0; cur_powerdown=2; cur_rate=0.
// 2. Rate 0->2 at cycle T -> one-cycle PhyStatus pulse at T+16; cur_rate=2; busy falls at T+17.
// 3. P1, TxElecIdle='1, TxDetectRxLoopback=16'h000F, RX_PRESENT=16'h0005:
//    -> at T+12, RxStatus lanes 0 and 2 = 3'b011, all other lanes 3'b000.
//    -> busy stays high until detect is dropped.
// 4. Rate 0->1 and PowerDown 2->0 at the same edge T:
//    -> PhyStatus pulses at T+16 (cur_rate=1) and at T+17+4=T+21 (cur_powerdown=0).
// 5. Reset asserted 5 cycles into RATE_CHG -> no completion pulse; PhyStatus='1; cur_rate=0; RST_WAIT restarts.
// 6. PowerDown=4'hF or Rate=4'h7 held for 50 cycles -> no PhyStatus pulse; busy=0; cur_* unchanged.

Source files
------------

// File: rtl/pipe_phy_cmd_ctrl.sv
// pipe_phy_cmd_ctrl
//   PHY-side responder for the PIPE command/status signals. It answers reset
//   completion, Rate and PowerDown change requests, and receiver detection
//   with PhyStatus pulses and per-lane RxStatus.
// Ports
//   PCLK, Reset            : clock; synchronous active-high reset
//   PowerDown[3:0]         : requested power state (0..3 legal)
//   Rate[3:0]              : requested rate (0..4 legal)
//   TxDetectRxLoopback[N]  : per-lane receiver-detect request
//   TxElecIdle[N]          : per-lane transmitter electrical idle
//   PhyStatus[N]           : completion pulse, identical on all lanes
//   RxStatus[3N]           : per-lane status, lane i in [3i+2:3i]
//   busy                   : high whenever the block is not IDLE
//   cur_rate, cur_powerdown: currently accepted Rate / PowerDown
module pipe_phy_cmd_ctrl #(
  parameter int unsigned          NUM_LANES  = 16,
  parameter int unsigned          RESET_LAT  = 8,
  parameter int unsigned          RATE_LAT   = 16,
  parameter int unsigned          PD_LAT     = 4,
  parameter int unsigned          DETECT_LAT = 12,
  parameter logic [NUM_LANES-1:0] RX_PRESENT = '1
) (
  input  logic                   PCLK,
  input  logic                   Reset,
  input  logic [3:0]             PowerDown,
  input  logic [3:0]             Rate,
  input  logic [NUM_LANES-1:0]   TxDetectRxLoopback,
  input  logic [NUM_LANES-1:0]   TxElecIdle,
  output logic [NUM_LANES-1:0]   PhyStatus,
  output logic [3*NUM_LANES-1:0] RxStatus,
  output logic                   busy,
  output logic [3:0]             cur_rate,
  output logic [3:0]             cur_powerdown
);

  localparam int unsigned MAX_A   = (RESET_LAT > RATE_LAT) ? RESET_LAT : RATE_LAT;
  localparam int unsigned MAX_B   = (PD_LAT > DETECT_LAT) ? PD_LAT : DETECT_LAT;
  localparam int unsigned MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_IDLE,
    ST_RATE_CHG,
    ST_PD_CHG,
    ST_DETECT,
    ST_DET_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   phy_q, phy_d;
  logic [3*NUM_LANES-1:0] rx_q, rx_d;
  logic [3:0]             rate_q, rate_d;
  logic [3:0]             pd_q, pd_d;
  logic [3:0]             cap_val_q, cap_val_d;
  logic [NUM_LANES-1:0]   cap_det_q, cap_det_d;
  logic [CNT_W-1:0]       lat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phy_d     = 1'b0;
    rx_d      = '0;
    rate_d    = rate_q;
    pd_d      = pd_q;
    cap_val_d = cap_val_q;
    cap_det_d = cap_det_q;

    case (state_q)
      ST_RATE_CHG: lat = CNT_W'(RATE_LAT);
      ST_PD_CHG:   lat = CNT_W'(PD_LAT);
      default:     lat = CNT_W'(DETECT_LAT);
    endcase

    case (state_q)
      ST_RST_WAIT: begin
        // Counter value k means k deasserted edges seen; PhyStatus falls
        // on the edge where RESET_LAT edges have already elapsed.
        phy_d = 1'b1;
        if (cnt_q == CNT_W'(RESET_LAT)) begin
          state_d = ST_IDLE;
          phy_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (Rate <= 4'd4 && Rate != rate_q) begin
          state_d   = ST_RATE_CHG;
          cap_val_d = Rate;
          cnt_d     = CNT_W'(1);
        end else if (PowerDown <= 4'd3 && PowerDown != pd_q) begin
          state_d   = ST_PD_CHG;
          cap_val_d = PowerDown;
          cnt_d     = CNT_W'(1);
        end else if (pd_q == 4'd2 && |TxDetectRxLoopback && &TxElecIdle) begin
          state_d   = ST_DETECT;
          cap_det_d = TxDetectRxLoopback;
          cnt_d     = CNT_W'(1);
        end
      end
      ST_RATE_CHG, ST_PD_CHG, ST_DETECT: begin
        // Outputs are registered, so completion is launched one count early
        // and the state lingers for the completion cycle itself.
        if (cnt_q == lat - 1'b1) begin
          phy_d = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_RATE_CHG) begin
            rate_d = cap_val_q;
          end else if (state_q == ST_PD_CHG) begin
            pd_d = cap_val_q;
          end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
              rx_d[3*i +: 3] = (cap_det_q[i] & RX_PRESENT[i]) ? 3'b011 : 3'b000;
            end
          end
        end else if (cnt_q == lat) begin
          cnt_d   = '0;
          state_d = (state_q == ST_DETECT) ? ST_DET_WAIT : ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DET_WAIT: begin
        if (TxDetectRxLoopback == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (Reset) begin
      state_q   <= ST_RST_WAIT;
      cnt_q     <= '0;
      phy_q     <= 1'b1;
      rx_q      <= '0;
      rate_q    <= 4'd0;
      pd_q      <= 4'd2;
      cap_val_q <= '0;
      cap_det_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phy_q     <= phy_d;
      rx_q      <= rx_d;
      rate_q    <= rate_d;
      pd_q      <= pd_d;
      cap_val_q <= cap_val_d;
      cap_det_q <= cap_det_d;
    end
  end

  assign PhyStatus     = {NUM_LANES{phy_q}};
  assign RxStatus      = rx_q;
  assign busy          = (state_q != ST_IDLE);
  assign cur_rate      = rate_q;
  assign cur_powerdown = pd_q;

endmodule

// File: tb/tb_pipe_phy_cmd_ctrl.sv
// tb_pipe_phy_cmd_ctrl
//   Directed bench for pipe_phy_cmd_ctrl. Inputs change and outputs are
//   checked on the falling edge of PCLK; "cycle T" is the cycle in which a
//   request is first presented while the block is IDLE.
module tb_pipe_phy_cmd_ctrl;

  localparam int unsigned N = 16;

  logic           PCLK;
  logic           Reset;
  logic [3:0]     PowerDown;
  logic [3:0]     Rate;
  logic [N-1:0]   TxDetectRxLoopback;
  logic [N-1:0]   TxElecIdle;
  logic [N-1:0]   PhyStatus;
  logic [3*N-1:0] RxStatus;
  logic           busy;
  logic [3:0]     cur_rate;
  logic [3:0]     cur_powerdown;

  int checks = 0;
  int errors = 0;

  pipe_phy_cmd_ctrl #(
    .NUM_LANES (N),
    .RESET_LAT (8),
    .RATE_LAT  (16),
    .PD_LAT    (4),
    .DETECT_LAT(12),
    .RX_PRESENT(16'h0005)
  ) dut (
    .PCLK              (PCLK),
    .Reset             (Reset),
    .PowerDown         (PowerDown),
    .Rate              (Rate),
    .TxDetectRxLoopback(TxDetectRxLoopback),
    .TxElecIdle        (TxElecIdle),
    .PhyStatus         (PhyStatus),
    .RxStatus          (RxStatus),
    .busy              (busy),
    .cur_rate          (cur_rate),
    .cur_powerdown     (cur_powerdown)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic step(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset              = 1'b1;
    PowerDown          = 4'd2;
    Rate               = 4'd0;
    TxDetectRxLoopback = '0;
    TxElecIdle         = '1;

    // 1: reset for 3 cycles, then 8 cycles of PhyStatus after deassert
    step(3);
    chk("rst_phy", 64'(PhyStatus), 64'hFFFF);
    chk("rst_rx", 64'(RxStatus), 64'h0);
    chk("rst_busy", 64'(busy), 64'h1);
    chk("rst_rate", 64'(cur_rate), 64'h0);
    chk("rst_pd", 64'(cur_powerdown), 64'h2);
    Reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk($sformatf("rstwait_phy_%0d", i), 64'(PhyStatus), 64'hFFFF);
    end
    step(1);
    chk("rstdone_phy", 64'(PhyStatus), 64'h0);
    chk("rstdone_busy", 64'(busy), 64'h0);
    chk("rstdone_pd", 64'(cur_powerdown), 64'h2);
    chk("rstdone_rate", 64'(cur_rate), 64'h0);

    // 2: Rate 0 -> 2, pulse at T+16, busy low at T+17
    Rate = 4'd2;
    step(1);
    chk("rate_busy_t1", 64'(busy), 64'h1);
    step(14);
    chk("rate_phy_t15", 64'(PhyStatus), 64'h0);
    chk("rate_cur_t15", 64'(cur_rate), 64'h0);
    step(1);
    chk("rate_phy_t16", 64'(PhyStatus), 64'hFFFF);
    chk("rate_cur_t16", 64'(cur_rate), 64'h2);
    chk("rate_busy_t16", 64'(busy), 64'h1);
    step(1);
    chk("rate_phy_t17", 64'(PhyStatus), 64'h0);
    chk("rate_busy_t17", 64'(busy), 64'h0);

    // 3: receiver detect in P1, lanes 0..3 requested, lanes 0 and 2 present
    TxDetectRxLoopback = 16'h000F;
    step(11);
    chk("det_phy_t11", 64'(PhyStatus), 64'h0);
    chk("det_rx_t11", 64'(RxStatus), 64'h0);
    step(1);
    chk("det_phy_t12", 64'(PhyStatus), 64'hFFFF);
    chk("det_rx_t12", 64'(RxStatus), 64'h0C3);
    step(1);
    chk("det_phy_t13", 64'(PhyStatus), 64'h0);
    chk("det_rx_t13", 64'(RxStatus), 64'h0);
    chk("det_busy_t13", 64'(busy), 64'h1);
    step(5);
    chk("det_busy_hold", 64'(busy), 64'h1);
    TxDetectRxLoopback = '0;
    step(1);
    chk("det_busy_drop", 64'(busy), 64'h0);

    // 4: Rate 2 -> 1 and PowerDown 2 -> 0 together; pulses at T+16 and T+21
    Rate      = 4'd1;
    PowerDown = 4'd0;
    step(16);
    chk("both_phy_t16", 64'(PhyStatus), 64'hFFFF);
    chk("both_rate_t16", 64'(cur_rate), 64'h1);
    chk("both_pd_t16", 64'(cur_powerdown), 64'h2);
    step(1);
    chk("both_phy_t17", 64'(PhyStatus), 64'h0);
    chk("both_busy_t17", 64'(busy), 64'h0);
    step(3);
    chk("both_phy_t20", 64'(PhyStatus), 64'h0);
    chk("both_pd_t20", 64'(cur_powerdown), 64'h2);
    step(1);
    chk("both_phy_t21", 64'(PhyStatus), 64'hFFFF);
    chk("both_pd_t21", 64'(cur_powerdown), 64'h0);
    step(1);
    chk("both_phy_t22", 64'(PhyStatus), 64'h0);
    chk("both_busy_t22", 64'(busy), 64'h0);

    // 5: reset 5 cycles into a rate change aborts it
    Rate = 4'd3;
    step(5);
    chk("abort_busy_t5", 64'(busy), 64'h1);
    Reset     = 1'b1;
    Rate      = 4'd0;
    PowerDown = 4'd2;
    step(1);
    chk("abort_phy", 64'(PhyStatus), 64'hFFFF);
    chk("abort_rate", 64'(cur_rate), 64'h0);
    chk("abort_pd", 64'(cur_powerdown), 64'h2);
    chk("abort_busy", 64'(busy), 64'h1);
    step(1);
    Reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      chk($sformatf("abort_wait_phy_%0d", i), 64'(PhyStatus), 64'hFFFF);
    end
    step(1);
    chk("abort_done_phy", 64'(PhyStatus), 64'h0);
    chk("abort_done_busy", 64'(busy), 64'h0);
    step(20);
    chk("abort_no_pulse", 64'(PhyStatus), 64'h0);
    chk("abort_rate_after", 64'(cur_rate), 64'h0);

    // 6: illegal PowerDown, then illegal Rate, each held 50 cycles
    PowerDown = 4'hF;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk($sformatf("ill_pd_phy_%0d", i), 64'(PhyStatus), 64'h0);
    end
    chk("ill_pd_busy", 64'(busy), 64'h0);
    chk("ill_pd_cur", 64'(cur_powerdown), 64'h2);
    PowerDown = 4'd2;
    Rate      = 4'h7;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk($sformatf("ill_rate_phy_%0d", i), 64'(PhyStatus), 64'h0);
    end
    chk("ill_rate_busy", 64'(busy), 64'h0);
    chk("ill_rate_cur", 64'(cur_rate), 64'h0);

    // Highest legal values are accepted
    Rate = 4'd4;
    step(16);
    chk("rate4_phy", 64'(PhyStatus), 64'hFFFF);
    chk("rate4_cur", 64'(cur_rate), 64'h4);
    step(1);
    PowerDown = 4'd3;
    step(4);
    chk("pd3_phy", 64'(PhyStatus), 64'hFFFF);
    chk("pd3_cur", 64'(cur_powerdown), 64'h3);
    step(2);
    chk("pd3_busy", 64'(busy), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
